// File: rtl/disp_ctrl_if.sv
// Switch-in / display-out signal bundle for the two-digit display controller.
// master drives switches and lz_en; slave (the controller) drives the display side.
interface disp_ctrl_if;
  logic [3:0] sw;
  logic       lz_en;
  logic [3:0] val;
  logic       dig_sel;
  logic       an0;
  logic       an1;
  logic       new_val;

  modport master (
    output sw,
    output lz_en,
    input  val,
    input  dig_sel,
    input  an0,
    input  an1,
    input  new_val
  );

  modport slave (
    input  sw,
    input  lz_en,
    output val,
    output dig_sel,
    output an0,
    output an1,
    output new_val
  );
endinterface

// File: rtl/disp_ctrl.sv
// Debounces a 4-bit switch value and time-multiplexes it onto two active-low digit
// anodes (units, then tens), with blanking gaps so dig_sel settles before an anode fires.
module disp_ctrl #(
  parameter int DEB_CNT = 100000,
  parameter int REFRESH = 50000,
  parameter int BLANK   = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  disp_ctrl_if.slave  bus
);

  localparam int CW  = $clog2(DEB_CNT);
  // REFRESH > BLANK, so the slot counter only has to reach REFRESH-1.
  localparam int SCW = $clog2(REFRESH);

  localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_CNT - 1);
  localparam logic [SCW-1:0] REF_LAST = SCW'(REFRESH - 1);
  localparam logic [SCW-1:0] BLK_LAST = SCW'(BLANK - 1);

  typedef enum logic [1:0] {
    BLK_U  = 2'd0,
    SHOW_U = 2'd1,
    BLK_T  = 2'd2,
    SHOW_T = 2'd3
  } scan_state_e;

  logic [3:0]     sw_meta_q, sw_meta_d;
  logic [3:0]     sw_s_q, sw_s_d;
  logic [3:0]     cand_q, cand_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     val_q, val_d;
  logic           new_val_q, new_val_d;

  scan_state_e    state_q, state_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic           dig_sel_q, dig_sel_d;
  logic           an0_q, an0_d;
  logic           an1_q, an1_d;

  always_comb begin
    sw_meta_d = bus.sw;
    sw_s_d    = sw_meta_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    new_val_d = 1'b0;

    if (sw_s_q != cand_q) begin
      cand_d = sw_s_q;
      cnt_d  = '0;
    end else if (cand_q != val_q) begin
      if (cnt_q == DEB_LAST) begin
        val_d     = cand_q;
        cnt_d     = '0;
        new_val_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q + 1'b1;

    case (state_q)
      BLK_U:   if (scnt_q == BLK_LAST) state_d = SHOW_U;
      SHOW_U:  if (scnt_q == REF_LAST) state_d = BLK_T;
      BLK_T:   if (scnt_q == BLK_LAST) state_d = SHOW_T;
      SHOW_T:  if (scnt_q == REF_LAST) state_d = BLK_U;
      default: state_d = BLK_U;
    endcase

    if (state_d != state_q) begin
      scnt_d = '0;
    end

    // Outputs are decoded from the upcoming state and value so the registered
    // anodes line up with state_q and val_q in the same cycle.
    an0_d     = 1'b1;
    an1_d     = 1'b1;
    dig_sel_d = 1'b1;
    case (state_d)
      BLK_U:   dig_sel_d = 1'b1;
      SHOW_U:  an0_d     = 1'b0;
      BLK_T:   dig_sel_d = 1'b0;
      SHOW_T: begin
        dig_sel_d = 1'b0;
        an1_d     = bus.lz_en && (val_d < 4'd10);
      end
      default: dig_sel_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      val_q     <= '0;
      new_val_q <= 1'b0;
      state_q   <= BLK_U;
      scnt_q    <= '0;
      dig_sel_q <= 1'b1;
      an0_q     <= 1'b1;
      an1_q     <= 1'b1;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_s_q    <= sw_s_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      val_q     <= val_d;
      new_val_q <= new_val_d;
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      dig_sel_q <= dig_sel_d;
      an0_q     <= an0_d;
      an1_q     <= an1_d;
    end
  end

  assign bus.val     = val_q;
  assign bus.new_val = new_val_q;
  assign bus.dig_sel = dig_sel_q;
  assign bus.an0     = an0_q;
  assign bus.an1     = an1_q;

endmodule

// File: doc/disp_ctrl.md
DISP_CTRL -- requirements
Module: disp_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 100000, is the number of consecutive stable cycles required to accept a new switch value (2..2^20).
REQ-002 Parameter REFRESH, default 50000, is the number of cycles each digit is lit per scan slot (2..2^20).
REQ-003 Parameter BLANK, default 500, is the number of all-anodes-off cycles between digit slots (1..REFRESH-1).
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 sw  input  4  raw asynchronous switch value, binary 0..15.
REQ-008 lz_en  input  1  1 = suppress the leading zero on the tens digit.
REQ-009 val  output  4  debounced switch value, drives the downstream decoder's 4-bit value input.
REQ-010 dig_sel  output  1  digit select for the downstream decoder: 1 = units nibble, 0 = tens nibble.
REQ-011 an0  output  1  units-digit anode, active-low.
REQ-012 an1  output  1  tens-digit anode, active-low.
REQ-013 new_val  output  1  one-cycle pulse when val changes.

Function
REQ-014 sw passes through a 2-flop synchronizer (sw_s); no other logic reads sw directly.
REQ-015 Debouncer holds a candidate register cand and a counter cnt: if sw_s != cand, then cand <= sw_s and cnt <= 0.
REQ-016 If sw_s == cand and cand != val, cnt increments; when cnt == DEB_CNT-1, val <= cand, cnt <= 0, and new_val is 1 for the following cycle.
REQ-017 If sw_s == cand == val, cnt holds at 0; a bounce shorter than DEB_CNT cycles never changes val.
REQ-018 Latency: a clean sw step held stable appears on val exactly DEB_CNT+3 rising edges after it is first sampled.
REQ-019 Scanner FSM states: BLK_U, SHOW_U, BLK_T, SHOW_T, using one slot counter scnt that clears on every state transition.
REQ-020 Transitions: BLK_U->SHOW_U and BLK_T->SHOW_T after BLANK cycles; SHOW_U->BLK_T and SHOW_T->BLK_U after REFRESH cycles; the order is fixed and wraps indefinitely.
REQ-021 Outputs are registered: SHOW_U gives an0=0, an1=1, dig_sel=1; SHOW_T gives an0=1, dig_sel=0, and an1=0 unless lz_en=1 and val<10, in which case an1=1.
REQ-022 BLK_U drives dig_sel=1; BLK_T drives dig_sel=0; both blank states drive an0=an1=1, so dig_sel settles before any anode asserts.
REQ-023 an0 and an1 are never 0 in the same cycle.
REQ-024 A val change mid-slot takes effect immediately on val; the scan timing is not disturbed, and the lz_en check uses the current val every cycle.
REQ-025 Full scan period is 2*(REFRESH+BLANK) cycles; each digit's duty is REFRESH/(2*(REFRESH+BLANK)).
REQ-026 Counter widths are sized from the parameters; counters have no overflow path because each clears at its terminal count.

Reset
REQ-027 While rst_n=0 at a rising edge: val=0, cand=0, cnt=0, sync flops=0, new_val=0, state=BLK_U, scnt=0, dig_sel=1, an0=1, an1=1.
REQ-028 Reset asserted mid-slot or mid-debounce aborts the operation with no partial update; the first cycle after release is cycle 0 of BLK_U.
REQ-029 After reset release, SHOW_U begins after BLANK cycles; a sw value already nonzero is accepted through the normal REQ-016 path.

Verification (DEB_CNT=4, REFRESH=8, BLANK=2)
REQ-030 Reset release with sw=0 -> an0=an1=1 for 2 cycles, then an0=0 for 8 cycles, then both high for 2 cycles, then an1=0 for 8 cycles; period is 20 cycles.
REQ-031 sw steps 0->9 and holds -> val=9 after exactly 7 edges, with new_val high for exactly 1 cycle.
REQ-032 sw toggles 0->5->0 with a 3-cycle glitch -> val stays 0 and new_val never pulses.
REQ-033 val=3 with lz_en=1 -> an1 stays 1 in SHOW_T while dig_sel=0; val=12 -> an1=0 in SHOW_T.
REQ-034 rst_n pulsed low for 1 cycle in the middle of SHOW_T with val=12 -> next cycle is BLK_U with val=0, an0=an1=1, dig_sel=1.
REQ-035 Every run checks an0&an1 never both 0, and dig_sel stable for at least 1 cycle before any anode falls.
